// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle slice adder.
package adder_pkg;

    // Control states of the multi-cycle adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices an operand is split into.
    function automatic int slice_count(input int width, input int slice);
        return (slice < 1) ? 1 : width / slice;
    endfunction

    // Slice counter width: at least one bit even for a single slice.
    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/ripple_adder_slice.sv
// SLICE-bit ripple-carry adder built from a chain of full-adder cells.
// Also exposes the carry into its MSB so the caller can form overflow.
module ripple_adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_c,
    output logic [SLICE-1:0] o_sum,
    output logic             o_c,
    output logic             o_c_msb
);

    logic [SLICE:0] w_c;

    assign w_c[0] = i_c;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_sum[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_c     = w_c[SLICE];
    assign o_c_msb = w_c[SLICE-1];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds SLICE bits per clock over N = WIDTH/SLICE
// cycles, with a single-entry valid/ready handshake on each side.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N          = slice_count(WIDTH, SLICE);
    localparam int CW         = count_width(N);
    localparam int SAFE_SLICE = (SLICE < 1) ? 1 : SLICE;

    if ((SLICE < 1) || ((WIDTH % SAFE_SLICE) != 0)) begin : g_bad_params
        $error("multicycle_adder: WIDTH must be a positive multiple of SLICE");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_f;
    logic [WIDTH-1:0] w_f_next;
    logic             r_carry;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_sum;
    logic             w_slice_c;
    logic             w_slice_c_msb;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_slice = r_a[k*SLICE +: SLICE];
                w_b_slice = r_b[k*SLICE +: SLICE];
            end
        end
    end

    ripple_adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_c     (r_carry),
        .o_sum   (w_sum),
        .o_c     (w_slice_c),
        .o_c_msb (w_slice_c_msb)
    );

    // Merge the fresh slice sum into the result word.
    always_comb begin
        w_f_next = r_f;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_f_next[k*SLICE +: SLICE] = w_sum;
            end
        end
    end

    // Operand capture, per-slice accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~borrow, so fold sub into b and carry.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= c_in ^ sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_f     <= w_f_next;
            r_carry <= w_slice_c;
            if (w_last) begin
                r_c_out <= w_slice_c;
                r_ovf   <= w_slice_c_msb ^ w_slice_c;
                r_zero  <= (w_f_next == '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign f     = r_f;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed-vector bench for multicycle_adder at SLICE=4 and SLICE=16.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_ready;

    logic        in_valid4;
    logic        in_ready4;
    logic        out_valid4;
    logic [15:0] f4;
    logic        c_out4;
    logic        ovf4;
    logic        zero4;

    logic        in_valid16;
    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] f16;
    logic        c_out16;
    logic        ovf16;
    logic        zero16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(16), .SLICE(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .f         (f4),
        .c_out     (c_out4),
        .ovf       (ovf4),
        .zero      (zero4)
    );

    multicycle_adder #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .f         (f16),
        .c_out     (c_out16),
        .ovf       (ovf16),
        .zero      (zero16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation to the selected DUT and check latency and result.
    task automatic run_op(input int sel, input string tag,
                          input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_c, input logic op_sub,
                          input logic [15:0] exp_f, input logic exp_c,
                          input logic exp_ovf, input int exp_lat);
        int guard;
        int lat;
        guard = 0;
        while (((sel == 16) ? in_ready16 : in_ready4) !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, "_in_ready"}, 32'((sel == 16) ? in_ready16 : in_ready4), 32'd1);
        a    = op_a;
        b    = op_b;
        c_in = op_c;
        sub  = op_sub;
        if (sel == 16) in_valid16 = 1'b1;
        else           in_valid4  = 1'b1;
        tick();
        in_valid4  = 1'b0;
        in_valid16 = 1'b0;
        // Scramble inputs while the operation is in flight.
        a    = ~op_a;
        b    = ~op_b;
        c_in = ~op_c;
        sub  = ~op_sub;
        lat  = 0;
        while (((sel == 16) ? out_valid16 : out_valid4) !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_f"},     32'((sel == 16) ? f16 : f4),         32'(exp_f));
        check({tag, "_c_out"}, 32'((sel == 16) ? c_out16 : c_out4), 32'(exp_c));
        check({tag, "_ovf"},   32'((sel == 16) ? ovf16 : ovf4),     32'(exp_ovf));
        check({tag, "_zero"},  32'((sel == 16) ? zero16 : zero4),   32'(exp_f == 16'h0000));
        tick();
    endtask

    initial begin
        int  lat;
        logic seen;
        rst        = 1'b1;
        in_valid4  = 1'b0;
        in_valid16 = 1'b0;
        a          = '0;
        b          = '0;
        c_in       = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready",    32'(in_ready4),   32'd1);
        check("rst_out_valid",   32'(out_valid4),  32'd0);
        check("rst_f",           32'(f4),          32'h0000);
        check("rst_zero",        32'(zero4),       32'd1);
        check("rst_c_out",       32'(c_out4),      32'd0);
        check("rst_ovf",         32'(ovf4),        32'd0);
        check("rst16_in_ready",  32'(in_ready16),  32'd1);
        check("rst16_out_valid", 32'(out_valid16), 32'd0);

        // Directed arithmetic vectors.
        run_op(4, "add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
        run_op(4, "add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
        run_op(4, "sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
        run_op(4, "sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);
        run_op(4, "sub_10_3_b1", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 4);
        run_op(4, "add_cin1",    16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 4);

        // Back-pressure in DONE: result holds, new operands are ignored.
        out_ready = 1'b0;
        a         = 16'h00F0;
        b         = 16'h000F;
        c_in      = 1'b0;
        sub       = 1'b0;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd4);
        a         = 16'h1111;
        b         = 16'h1111;
        in_valid4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_out_valid", 32'(out_valid4), 32'd1);
            check("hold_f",         32'(f4),         32'h00FF);
            check("hold_flags",     32'({c_out4, ovf4, zero4}), 32'b000);
            check("hold_in_ready",  32'(in_ready4),  32'd0);
            tick();
        end
        check("hold_f_last", 32'(f4), 32'h00FF);
        out_ready = 1'b1;
        tick();
        check("release_in_ready",  32'(in_ready4),  32'd1);
        check("release_out_valid", 32'(out_valid4), 32'd0);
        in_valid4 = 1'b0;
        tick();
        check("release_no_accept", 32'(in_ready4), 32'd1);

        // Reset in the middle of RUN aborts the operation.
        a         = 16'h0F0F;
        b         = 16'h0101;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready4),  32'd1);
        check("abort_out_valid", 32'(out_valid4), 32'd0);
        check("abort_f",         32'(f4),         32'h0000);
        check("abort_zero",      32'(zero4),      32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid4 === 1'b1) seen = 1'b1;
            tick();
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_op(4, "after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 4);

        // Single-slice configuration.
        run_op(16, "s16_add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1);
        run_op(16, "s16_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits added per cycle.
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: in_valid  input  1  operands present.
REQ-007 SHALL have port: in_ready  output  1  block accepts operands.
REQ-008 SHALL have port: a  input  WIDTH  operand A.
REQ-009 SHALL have port: b  input  WIDTH  operand B.
REQ-010 SHALL have port: c_in  input  1  carry-in (add) or borrow-in (sub).
REQ-011 SHALL have port: sub  input  1  0 = add, 1 = subtract.
REQ-012 SHALL have port: out_valid  output  1  result present.
REQ-013 SHALL have port: out_ready  input  1  consumer takes result.
REQ-014 SHALL have port: f  output  WIDTH  sum/difference.
REQ-015 SHALL have port: c_out  output  1  raw carry out of MSB.
REQ-016 SHALL have port: ovf  output  1  two's-complement overflow.
REQ-017 SHALL have port: zero  output  1  f == 0.

Function
REQ-018 SHALL be elaborated only when WIDTH % SLICE == 0 and SLICE >= 1; otherwise elaboration SHALL fail with an error.
REQ-019 SHALL use an FSM with states IDLE, RUN and DONE, where N = WIDTH/SLICE.
REQ-020 SHALL assert in_ready only in IDLE.
REQ-021 SHALL accept an operand set on an edge where in_valid && in_ready: latch a, b XOR {WIDTH{sub}}, and carry = c_in XOR sub; clear the slice counter; go to RUN.
REQ-022 SHALL, in RUN, add slice k (bits k*SLICE+SLICE-1 : k*SLICE) of the latched operands plus the carry register on each edge, write the slice result into f, and update the carry register, for k = 0..N-1.
REQ-023 SHALL go to DONE after the edge that adds slice N-1.
REQ-024 SHALL assert out_valid exactly N cycles after the accepting edge (on the cycle following edge N).
REQ-025 SHALL assert out_valid only in DONE.
REQ-026 SHALL, in DONE, hold f, c_out, ovf and zero stable until an edge with out_ready = 1, then go to IDLE.
REQ-027 SHALL NOT accept new operands on the edge that leaves DONE (single-entry pipeline).
REQ-028 SHALL, when sub = 1, produce f = a - b - c_in mod 2^WIDTH, so that c_out = 1 means no borrow.
REQ-029 SHALL set c_out = carry out of bit WIDTH-1.
REQ-030 SHALL set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured during the last slice.
REQ-031 SHALL set zero = (f == 0); it SHALL be valid whenever out_valid = 1.
REQ-032 SHALL ignore a, b, c_in and sub in RUN and DONE (no effect on the result in flight).
REQ-033 SHALL, when SLICE == WIDTH, set N = 1: one RUN cycle, out_valid one cycle after the accepting edge.
REQ-034 SHALL size the slice counter at max(1, $clog2(N)) bits; the counter SHALL NOT wrap during a single operation.

Reset
REQ-035 SHALL, when rst is high on an edge, set state to IDLE, clear f, c_out, ovf, the carry register and the slice counter, and set zero = 1.
REQ-036 SHALL hold out_valid = 0 and in_ready = 1 on the cycle after reset.
REQ-037 SHALL let reset in RUN or DONE abort the operation with no output handshake.
REQ-038 SHALL give rst priority over in_valid and out_ready on the same edge.

Structure
REQ-039 SHALL take the FSM state enum type (IDLE/RUN/DONE) from the shared package adder_pkg.
REQ-040 SHALL place the slice-count helper function in adder_pkg.
REQ-041 SHALL implement the per-slice add in sub-module ripple_adder_slice (parameter SLICE), built as a generate chain of the existing full-adder cell.
REQ-042 SHALL have ripple_adder_slice additionally output the carry into its MSB (used for ovf).

Verification
Each scenario runs at WIDTH=16, SLICE=4, out_ready=1 unless stated.
REQ-043 SHALL be tested with a=FFFF, b=0001, c_in=0, sub=0 -> f=0000, c_out=1, ovf=0, zero=1, out_valid 4 cycles after accept.
REQ-044 SHALL be tested with a=7FFF, b=0001, sub=0 -> f=8000, c_out=0, ovf=1, zero=0.
REQ-045 SHALL be tested with a=0005, b=0007, sub=1, c_in=0 -> f=FFFE, c_out=0, ovf=0, and with a=8000, b=0001, sub=1 -> f=7FFF, c_out=1, ovf=1.
REQ-046 SHALL be tested with out_ready held 0 for 3 cycles in DONE -> f and flags stable, in_ready=0, in_valid ignored; the release edge -> IDLE, in_ready=1 next cycle.
REQ-047 SHALL be tested with rst pulsed at RUN cycle 2 -> next cycle state IDLE, f=0000, zero=1, out_valid never asserted for that operation; a following 1234+1111 -> f=2345.
REQ-048 SHALL be tested with SLICE=16 and a=00FF, b=0001 -> f=0100 with out_valid 1 cycle after accept.
